// File: rtl/kbd_scan_decoder_pkg.sv
// Shared constants, FSM state type and helpers for the PS/2 set-2 scancode decoder.
package kbd_scan_decoder_pkg;

  localparam logic [1:0] FUNC_NONE  = 2'd0;
  localparam logic [1:0] FUNC_ENTER = 2'd1;
  localparam logic [1:0] FUNC_BKSP  = 2'd2;
  localparam logic [1:0] FUNC_CHAR  = 2'd3;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_BS  = 8'h08;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_POP  = 3'd1,
    S_WAIT = 3'd2,
    S_PROC = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  function automatic logic is_shift(input logic [7:0] code);
    return (code == SC_LSHIFT) || (code == SC_RSHIFT);
  endfunction

endpackage

// File: rtl/kbd_scan_decoder_if.sv
// Bundle of the receiver-FIFO side signals and the decoded key-event outputs.
interface kbd_scan_decoder_if;

  logic [7:0] ps2_data;
  logic       ps2_ready;
  logic       ps2_overflow;
  logic       nextdata_n;
  logic [7:0] ascii;
  logic [1:0] func_char;
  logic       press;
  logic       one_char_flag;
  logic       caps;
  logic [7:0] key_count;

  modport master (
    output ps2_data, ps2_ready, ps2_overflow,
    input  nextdata_n, ascii, func_char, press, one_char_flag, caps, key_count
  );

  modport slave (
    input  ps2_data, ps2_ready, ps2_overflow,
    output nextdata_n, ascii, func_char, press, one_char_flag, caps, key_count
  );

endinterface

// File: rtl/kbd_scan_decoder_scan2ascii.sv
// Combinational set-2 scancode to ASCII/func_char translation with shift and caps-lock.
module kbd_scan2ascii
  import kbd_scan_decoder_pkg::*;
(
  input  logic [7:0] scancode,
  input  logic       shift,
  input  logic       caps,
  output logic [7:0] ascii,
  output logic [1:0] func_char
);

  logic [7:0] lower_s;
  logic [7:0] upper_s;
  logic       letter_s;

  // Table lookup: letters carry only the lowercase code, others carry both shift levels
  always_comb begin
    lower_s  = 8'h00;
    upper_s  = 8'h00;
    letter_s = 1'b0;
    case (scancode)
      8'h1C: begin lower_s = 8'h61; letter_s = 1'b1; end
      8'h32: begin lower_s = 8'h62; letter_s = 1'b1; end
      8'h21: begin lower_s = 8'h63; letter_s = 1'b1; end
      8'h23: begin lower_s = 8'h64; letter_s = 1'b1; end
      8'h24: begin lower_s = 8'h65; letter_s = 1'b1; end
      8'h2B: begin lower_s = 8'h66; letter_s = 1'b1; end
      8'h34: begin lower_s = 8'h67; letter_s = 1'b1; end
      8'h33: begin lower_s = 8'h68; letter_s = 1'b1; end
      8'h43: begin lower_s = 8'h69; letter_s = 1'b1; end
      8'h3B: begin lower_s = 8'h6A; letter_s = 1'b1; end
      8'h42: begin lower_s = 8'h6B; letter_s = 1'b1; end
      8'h4B: begin lower_s = 8'h6C; letter_s = 1'b1; end
      8'h3A: begin lower_s = 8'h6D; letter_s = 1'b1; end
      8'h31: begin lower_s = 8'h6E; letter_s = 1'b1; end
      8'h44: begin lower_s = 8'h6F; letter_s = 1'b1; end
      8'h4D: begin lower_s = 8'h70; letter_s = 1'b1; end
      8'h15: begin lower_s = 8'h71; letter_s = 1'b1; end
      8'h2D: begin lower_s = 8'h72; letter_s = 1'b1; end
      8'h1B: begin lower_s = 8'h73; letter_s = 1'b1; end
      8'h2C: begin lower_s = 8'h74; letter_s = 1'b1; end
      8'h3C: begin lower_s = 8'h75; letter_s = 1'b1; end
      8'h2A: begin lower_s = 8'h76; letter_s = 1'b1; end
      8'h1D: begin lower_s = 8'h77; letter_s = 1'b1; end
      8'h22: begin lower_s = 8'h78; letter_s = 1'b1; end
      8'h35: begin lower_s = 8'h79; letter_s = 1'b1; end
      8'h1A: begin lower_s = 8'h7A; letter_s = 1'b1; end
      8'h16: begin lower_s = 8'h31; upper_s = 8'h21; end
      8'h1E: begin lower_s = 8'h32; upper_s = 8'h40; end
      8'h26: begin lower_s = 8'h33; upper_s = 8'h23; end
      8'h25: begin lower_s = 8'h34; upper_s = 8'h24; end
      8'h2E: begin lower_s = 8'h35; upper_s = 8'h25; end
      8'h36: begin lower_s = 8'h36; upper_s = 8'h5E; end
      8'h3D: begin lower_s = 8'h37; upper_s = 8'h26; end
      8'h3E: begin lower_s = 8'h38; upper_s = 8'h2A; end
      8'h46: begin lower_s = 8'h39; upper_s = 8'h28; end
      8'h45: begin lower_s = 8'h30; upper_s = 8'h29; end
      8'h29: begin lower_s = 8'h20; upper_s = 8'h20; end
      8'h49: begin lower_s = 8'h2E; upper_s = 8'h3E; end
      8'h4A: begin lower_s = 8'h2F; upper_s = 8'h3F; end
      8'h4E: begin lower_s = 8'h2D; upper_s = 8'h5F; end
      8'h41: begin lower_s = 8'h2C; upper_s = 8'h3C; end
      8'h55: begin lower_s = 8'h3D; upper_s = 8'h2B; end
      8'h4C: begin lower_s = 8'h3B; upper_s = 8'h3A; end
      8'h52: begin lower_s = 8'h27; upper_s = 8'h22; end
      default: begin
        lower_s  = 8'h00;
        upper_s  = 8'h00;
        letter_s = 1'b0;
      end
    endcase
  end

  // Resolve shift level and classify the key
  always_comb begin
    ascii     = 8'h00;
    func_char = FUNC_NONE;
    if (scancode == SC_ENTER) begin
      ascii     = ASCII_CR;
      func_char = FUNC_ENTER;
    end else if (scancode == SC_BKSP) begin
      ascii     = ASCII_BS;
      func_char = FUNC_BKSP;
    end else begin
      if (letter_s) begin
        ascii = (shift ^ caps) ? (lower_s & 8'hDF) : lower_s;
      end else begin
        ascii = shift ? upper_s : lower_s;
      end
      func_char = (ascii != 8'h00) ? FUNC_CHAR : FUNC_NONE;
    end
  end

endmodule

// File: rtl/kbd_scan_decoder.sv
// Pops scancode bytes from the PS/2 FIFO and turns them into held-key events, caps state and a make counter.
module kbd_scan_decoder
  import kbd_scan_decoder_pkg::*;
#(
  parameter int GAP_CYCLES = 4
) (
  input  logic               clk,
  input  logic               clrn,
  kbd_scan_decoder_if.slave  bus
);

  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t     state_r;
  logic [7:0] byte_r;
  logic [7:0] held_code_r;
  logic [7:0] gap_cnt_r;
  logic       shift_r;
  logic       brk_r;
  logic       ext_r;
  logic       nextdata_n_r;
  logic [7:0] ascii_r;
  logic [1:0] func_char_r;
  logic       press_r;
  logic       one_char_flag_r;
  logic       caps_r;
  logic [7:0] key_count_r;
  logic [7:0] map_ascii_s;
  logic [1:0] map_func_s;

  kbd_scan2ascii u_scan2ascii (
    .scancode  (byte_r),
    .shift     (shift_r),
    .caps      (caps_r),
    .ascii     (map_ascii_s),
    .func_char (map_func_s)
  );

  // Decoder FSM with all flags, output registers and the make counter
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_r         <= S_IDLE;
      byte_r          <= 8'h00;
      held_code_r     <= 8'h00;
      gap_cnt_r       <= 8'h00;
      shift_r         <= 1'b0;
      brk_r           <= 1'b0;
      ext_r           <= 1'b0;
      nextdata_n_r    <= 1'b1;
      ascii_r         <= 8'h00;
      func_char_r     <= FUNC_NONE;
      press_r         <= 1'b0;
      one_char_flag_r <= 1'b0;
      caps_r          <= 1'b0;
      key_count_r     <= 8'h00;
    end else begin
      nextdata_n_r <= 1'b1;
      case (state_r)
        S_IDLE: begin
          state_r <= bus.ps2_ready ? S_POP : S_IDLE;
        end
        S_POP: begin
          if (bus.ps2_ready) begin
            byte_r       <= bus.ps2_data;
            nextdata_n_r <= 1'b0;
            state_r      <= S_WAIT;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_WAIT: begin
          state_r <= S_PROC;
        end
        S_PROC: begin
          state_r <= S_IDLE;
          if (byte_r == SC_EXT) begin
            ext_r <= 1'b1;
          end else if (byte_r == SC_BREAK) begin
            brk_r <= 1'b1;
          end else if (ext_r) begin
            ext_r <= 1'b0;
            brk_r <= 1'b0;
          end else if (brk_r) begin
            // ascii/func_char are left alone so a release consumer still sees the key
            if (is_shift(byte_r)) begin
              shift_r <= 1'b0;
            end else begin
              shift_r <= shift_r;
            end
            if (byte_r == held_code_r) begin
              press_r         <= 1'b0;
              one_char_flag_r <= 1'b0;
              held_code_r     <= 8'h00;
            end else begin
              held_code_r <= held_code_r;
            end
            brk_r <= 1'b0;
          end else if (is_shift(byte_r)) begin
            shift_r <= 1'b1;
          end else if (byte_r == SC_CAPS) begin
            // Typematic repeats of caps-lock must not keep toggling it
            if (held_code_r != SC_CAPS) begin
              caps_r <= ~caps_r;
            end else begin
              caps_r <= caps_r;
            end
            held_code_r <= SC_CAPS;
          end else if (press_r && (byte_r == held_code_r)) begin
            held_code_r <= held_code_r;
          end else if (press_r) begin
            press_r         <= 1'b0;
            one_char_flag_r <= 1'b0;
            gap_cnt_r       <= 8'h00;
            state_r         <= S_GAP;
          end else begin
            ascii_r         <= map_ascii_s;
            func_char_r     <= map_func_s;
            press_r         <= 1'b1;
            one_char_flag_r <= (map_func_s != FUNC_NONE);
            held_code_r     <= byte_r;
            key_count_r     <= key_count_r + 8'd1;
          end
        end
        S_GAP: begin
          // byte_r still holds the rolled-over key since no pop happens here
          if (gap_cnt_r == GAP_LAST) begin
            ascii_r         <= map_ascii_s;
            func_char_r     <= map_func_s;
            press_r         <= 1'b1;
            one_char_flag_r <= (map_func_s != FUNC_NONE);
            held_code_r     <= byte_r;
            key_count_r     <= key_count_r + 8'd1;
            state_r         <= S_IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r + 8'd1;
            state_r   <= S_GAP;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
      if (bus.ps2_overflow) begin
        brk_r <= 1'b0;
        ext_r <= 1'b0;
      end
    end
  end

  assign bus.nextdata_n    = nextdata_n_r;
  assign bus.ascii         = ascii_r;
  assign bus.func_char     = func_char_r;
  assign bus.press         = press_r;
  assign bus.one_char_flag = one_char_flag_r;
  assign bus.caps          = caps_r;
  assign bus.key_count     = key_count_r;

endmodule

// File: tb/tb_kbd_scan_decoder.sv
// Directed bench for kbd_scan_decoder: feeds scancode bytes through a one-byte FIFO model.
module tb_kbd_scan_decoder;

  logic clk;
  logic clrn;
  int   checks;
  int   errors;
  int   nd_low_cycles;
  int   nd_falls;
  int   nd_double;
  int   press_rises;
  int   press_falls;
  logic prev_nd;
  logic prev_press;

  kbd_scan_decoder_if bus ();

  kbd_scan_decoder #(.GAP_CYCLES(4)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pop-strobe and press-edge monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.nextdata_n === 1'b0) nd_low_cycles++;
    if (bus.nextdata_n === 1'b0 && prev_nd === 1'b0) nd_double++;
    if (bus.nextdata_n === 1'b0 && prev_nd === 1'b1) nd_falls++;
    if (bus.press === 1'b1 && prev_press === 1'b0) press_rises++;
    if (bus.press === 1'b0 && prev_press === 1'b1) press_falls++;
    prev_nd    = bus.nextdata_n;
    prev_press = bus.press;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte, wait for the pop strobe, then let the decoder process it
  task automatic send(input logic [7:0] b);
    bit seen;
    seen = 1'b0;
    bus.ps2_data  = b;
    bus.ps2_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.nextdata_n === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("pop_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.ps2_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic key_out(input string tag, input logic [7:0] a, input logic [1:0] f,
                         input logic p, input logic o, input logic [7:0] kc);
    chk({tag, "_ascii"}, {24'd0, bus.ascii}, {24'd0, a});
    chk({tag, "_func"},  {30'd0, bus.func_char}, {30'd0, f});
    chk({tag, "_press"}, {31'd0, bus.press}, {31'd0, p});
    chk({tag, "_ocf"},   {31'd0, bus.one_char_flag}, {31'd0, o});
    chk({tag, "_count"}, {24'd0, bus.key_count}, {24'd0, kc});
  endtask

  initial begin
    int base_low;
    int base_falls;
    int base_rise;
    int base_pfall;
    int low_run;
    int bad_ascii;
    checks        = 0;
    errors        = 0;
    nd_low_cycles = 0;
    nd_falls      = 0;
    nd_double     = 0;
    press_rises   = 0;
    press_falls   = 0;
    prev_nd       = 1'b1;
    prev_press    = 1'b0;
    clrn             = 1'b0;
    bus.ps2_data     = 8'h00;
    bus.ps2_ready    = 1'b0;
    bus.ps2_overflow = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_nextdata_n", {31'd0, bus.nextdata_n}, 32'd1);
    chk("rst_caps", {31'd0, bus.caps}, 32'd0);
    key_out("rst", 8'h00, 2'd0, 1'b0, 1'b0, 8'd0);
    clrn = 1'b1;
    repeat (2) @(negedge clk);

    // Plain make / break of 'f'
    send(8'h2B);
    key_out("t1_make", 8'h66, 2'd3, 1'b1, 1'b1, 8'd1);
    send(8'hF0);
    chk("t1_f0_press", {31'd0, bus.press}, 32'd1);
    send(8'h2B);
    key_out("t1_break", 8'h66, 2'd3, 1'b0, 1'b0, 8'd1);

    // Shift, caps-lock and their combination on 'a'
    send(8'h12); send(8'h1C);
    key_out("t2_shift_a", 8'h41, 2'd3, 1'b1, 1'b1, 8'd2);
    send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    chk("t2_rel_press", {31'd0, bus.press}, 32'd0);
    send(8'h58);
    chk("t2_caps_on", {31'd0, bus.caps}, 32'd1);
    send(8'hF0); send(8'h58); send(8'h1C);
    key_out("t2_caps_a", 8'h41, 2'd3, 1'b1, 1'b1, 8'd3);
    send(8'hF0); send(8'h1C); send(8'h12); send(8'h1C);
    key_out("t2_both_a", 8'h61, 2'd3, 1'b1, 1'b1, 8'd4);
    send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    send(8'h58); send(8'hF0); send(8'h58);
    chk("t2_caps_off", {31'd0, bus.caps}, 32'd0);

    // Enter, backspace, shifted digit, unmapped key
    send(8'h5A);
    key_out("t3_enter", 8'h0D, 2'd1, 1'b1, 1'b1, 8'd5);
    send(8'hF0); send(8'h5A);
    key_out("t3_enter_rel", 8'h0D, 2'd1, 1'b0, 1'b0, 8'd5);
    send(8'h66);
    key_out("t3_bksp", 8'h08, 2'd2, 1'b1, 1'b1, 8'd6);
    send(8'hF0); send(8'h66);
    chk("t3_bksp_ocf", {31'd0, bus.one_char_flag}, 32'd0);
    send(8'h12); send(8'h16);
    key_out("t3_bang", 8'h21, 2'd3, 1'b1, 1'b1, 8'd7);
    send(8'hF0); send(8'h16); send(8'hF0); send(8'h12);
    send(8'h05);
    key_out("t3_unmapped", 8'h00, 2'd0, 1'b1, 1'b0, 8'd8);
    send(8'hF0); send(8'h05);
    chk("t3_unmapped_rel", {31'd0, bus.press}, 32'd0);

    // Typematic repeat is ignored
    base_low   = nd_low_cycles;
    base_falls = nd_falls;
    base_rise  = press_rises;
    base_pfall = press_falls;
    send(8'h2B); send(8'h2B); send(8'h2B);
    chk("t4_pop_cycles", nd_low_cycles - base_low, 32'd3);
    chk("t4_pop_strobes", nd_falls - base_falls, 32'd3);
    send(8'hF0); send(8'h2B);
    chk("t4_count", {24'd0, bus.key_count}, 32'd9);
    chk("t4_rises", press_rises - base_rise, 32'd1);
    chk("t4_falls", press_falls - base_pfall, 32'd1);

    // Rollover: new make while a key is held opens a 4-cycle gap
    send(8'h2B);
    key_out("t5_first", 8'h66, 2'd3, 1'b1, 1'b1, 8'd10);
    send(8'h34);
    low_run   = 0;
    bad_ascii = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.press !== 1'b0) break;
      low_run++;
      if (bus.ascii !== 8'h66) bad_ascii++;
      @(negedge clk);
    end
    chk("t5_gap_len", low_run, 32'd4);
    chk("t5_gap_ascii", bad_ascii, 32'd0);
    key_out("t5_second", 8'h67, 2'd3, 1'b1, 1'b1, 8'd11);
    send(8'hF0); send(8'h34);
    chk("t5_rel", {31'd0, bus.press}, 32'd0);

    // Reset mid-sequence drops the pending break; extended codes are swallowed
    send(8'hF0);
    @(negedge clk);
    clrn = 1'b0;
    #2;
    clrn = 1'b1;
    @(negedge clk);
    chk("t6_rst_count", {24'd0, bus.key_count}, 32'd0);
    send(8'h2B);
    key_out("t6_make", 8'h66, 2'd3, 1'b1, 1'b1, 8'd1);
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    key_out("t6_ext", 8'h66, 2'd3, 1'b1, 1'b1, 8'd1);
    send(8'hF0); send(8'h2B);
    chk("t6_rel", {31'd0, bus.press}, 32'd0);

    // Overflow discards a pending break
    send(8'hF0);
    bus.ps2_overflow = 1'b1;
    @(negedge clk);
    bus.ps2_overflow = 1'b0;
    send(8'h1C);
    key_out("t7_ovf", 8'h61, 2'd3, 1'b1, 1'b1, 8'd2);

    chk("pop_never_double", nd_double, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
